requant_pool_unit: RTL and testbench

Multi-channel post-convolution stage for the accelerator's layer datapath. It takes CH parallel accumulator lanes from the conv engines and applies per-channel bias, a programmable rounding shift, optional ReLU and saturation to OUT_W bits. It then optionally applies 2x2 max or average pooling. This block replaces the fixed shift/ReLU/maxpool chain with a runtime-configurable, frame-controlled unit.

---
 rtl/requant_pool_unit_pkg.sv | 14 +
 rtl/requant_pool_unit_lane.sv | 34 +++
 rtl/requant_pool_unit.sv | 142 ++++++++++++++
 tb/tb_requant_pool_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pool_unit_pkg.sv
// rpu_pkg: shared types and helpers for the requant/pool unit.
package rpu_pkg;
    typedef enum logic [1:0] {PM_BYPASS = 2'd0, PM_MAX = 2'd1, PM_AVG = 2'd2, PM_RSVD = 2'd3} pool_mode_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    localparam int OUT_W_DEF = 8;
    localparam int POOL_W = OUT_W_DEF + 2;
    function automatic logic signed [63:0] sat_to_out(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/requant_pool_unit_lane.sv
// requant_lane: bias add + round-half-up shift (stage 1), relu + saturate (stage 2).
module requant_lane
    import rpu_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic                     relu,
    output logic signed [OUT_W-1:0]  q
);
    logic signed [ACC_W+1:0] sum, inc, rnd, s1, r;
    // one guard bit above the exact ACC_W+1 sum keeps the rounding add from overflowing
    always_comb begin
        sum = (ACC_W+2)'(acc) + (ACC_W+2)'(bias);
        inc = shift == '0 ? '0 : (ACC_W+2)'(1) <<< (shift - 1'b1);
        rnd = (sum + inc) >>> shift;
        r   = relu && s1 < 0 ? '0 : s1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= rnd;
            q  <= OUT_W'(sat_to_out(64'(r), OUT_W));
        end
    end
endmodule

// File: rtl/requant_pool_unit.sv
// requant_pool_unit: per-lane requantisation followed by optional 2x2 max/avg pooling,
// driven one frame at a time by a small IDLE/RUN/DRAIN controller.
module requant_pool_unit
    import rpu_pkg::*;
#(
    parameter int CH         = 1,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int MAP_WIDTH  = 28,
    parameter int MAP_HEIGHT = 28,
    parameter int SHIFT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic                  cfg_relu,
    input  logic [1:0]            cfg_pool_mode,
    input  logic [CH*ACC_W-1:0]   cfg_bias,
    input  logic                  valid_in,
    input  logic [CH*ACC_W-1:0]   acc_in,
    output logic                  valid_out,
    output logic [CH*OUT_W-1:0]   pixel_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err_overrun
);
    localparam int N   = MAP_WIDTH * MAP_HEIGHT;
    localparam int CW  = $clog2(MAP_WIDTH);
    localparam int RW  = $clog2(MAP_HEIGHT);
    localparam int NW  = $clog2(N + 1);
    localparam int PW  = POOL_W - OUT_W_DEF + OUT_W;
    localparam int LBN = MAP_WIDTH / 2;
    state_e state, state_n;
    logic [SHIFT_W-1:0] shift_q;
    logic relu_q;
    pool_mode_e mode_q;
    logic [CH*ACC_W-1:0] bias_q;
    logic [NW-1:0] in_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic v1, v2, v3, last3, take, accept, pool, last2, win_end, done;
    always_comb begin
        take       = state == IDLE && start;
        accept     = state == RUN && valid_in;
        pool       = mode_q == PM_MAX || mode_q == PM_AVG;
        last2      = v2 && col == CW'(MAP_WIDTH - 1) && row == RW'(MAP_HEIGHT - 1);
        win_end    = v2 && col[0] && row[0];
        done       = pool ? v3 && last3 : last2;
        valid_out  = pool ? v3 : v2;
        frame_done = done;
        busy       = state != IDLE;
        state_n    = state;
        if (take)
            state_n = RUN;
        else if (accept && in_cnt == NW'(N - 1))
            state_n = DRAIN;
        else if (state == DRAIN && done)
            state_n = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            mode_q      <= PM_BYPASS;
            bias_q      <= '0;
            in_cnt      <= '0;
            col         <= '0;
            row         <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            last3       <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_n;
            v1    <= accept;
            v2    <= v1;
            v3    <= win_end && pool;
            last3 <= last2;
            if (take) begin
                shift_q     <= cfg_shift;
                relu_q      <= cfg_relu;
                mode_q      <= pool_mode_e'(cfg_pool_mode);
                bias_q      <= cfg_bias;
                in_cnt      <= '0;
                col         <= '0;
                row         <= '0;
                err_overrun <= 1'b0;
            end else begin
                if (valid_in && state != RUN)
                    err_overrun <= 1'b1;
                if (accept)
                    in_cnt <= in_cnt + NW'(1);
                else if (done)
                    in_cnt <= '0;
                if (v2) begin
                    col <= col == CW'(MAP_WIDTH - 1) ? '0 : col + CW'(1);
                    if (col == CW'(MAP_WIDTH - 1))
                        row <= row == RW'(MAP_HEIGHT - 1) ? '0 : row + RW'(1);
                end
            end
        end
    end
    for (genvar g = 0; g < CH; g++) begin : gen_lane
        logic signed [OUT_W-1:0] q2, hold, wmax, res, pool_q;
        logic signed [OUT_W:0] pair, ent;
        logic signed [OUT_W:0] lb [LBN];
        logic signed [PW-1:0] wsum;
        requant_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .acc   (acc_in[g*ACC_W +: ACC_W]),
            .bias  (bias_q[g*ACC_W +: ACC_W]),
            .shift (shift_q),
            .relu  (relu_q),
            .q     (q2)
        );
        // even rows fold their horizontal pair into lb; odd rows combine with it
        always_comb begin
            pair = mode_q == PM_MAX ? (OUT_W+1)'(q2 > hold ? q2 : hold) : (OUT_W+1)'(q2) + (OUT_W+1)'(hold);
            ent  = lb[col[CW-1:1]];
            wmax = OUT_W'(pair > ent ? pair : ent);
            wsum = PW'(pair) + PW'(ent);
            res  = mode_q == PM_MAX ? wmax : OUT_W'(wsum >>> 2);
        end
        always_ff @(posedge clk) begin
            if (v2 && !col[0])
                hold <= q2;
            if (v2 && col[0] && !row[0])
                lb[col[CW-1:1]] <= pair;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                pool_q <= '0;
            else if (win_end)
                pool_q <= res;
        end
        assign pixel_out[g*OUT_W +: OUT_W] = pool ? pool_q : q2;
    end
endmodule

// File: tb/tb_requant_pool_unit.sv
// tb_requant_pool_unit: random and directed frames checked against an arithmetic
// model of requantisation and 2x2 pooling, including output timing and frame_done.
module tb_requant_pool_unit;
    localparam int CH = 2, ACC_W = 32, OUT_W = 8, W = 4, H = 4, SW = 5, N = W * H;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_relu = 1'b0, valid_in = 1'b0;
    logic [SW-1:0] cfg_shift = '0;
    logic [1:0] cfg_pool_mode = '0;
    logic [CH*ACC_W-1:0] cfg_bias = '0, acc_in = '0;
    logic valid_out, busy, frame_done, err_overrun;
    logic [CH*OUT_W-1:0] pixel_out;

    requant_pool_unit #(.CH(CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .MAP_WIDTH(W), .MAP_HEIGHT(H), .SHIFT_W(SW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .cfg_pool_mode (cfg_pool_mode),
        .cfg_bias      (cfg_bias),
        .valid_in      (valid_in),
        .acc_in        (acc_in),
        .valid_out     (valid_out),
        .pixel_out     (pixel_out),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int p0;
        int p1;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int cyc = 0;
    int n_chk = 0, n_err = 0;
    int acc_d[CH][N];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input longint got, input longint want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if (n % d != 0 && n < 0)
            q = q - 1;
        return q;
    endfunction

    function automatic int rq(input longint a, input longint b, input int sh, input bit relu);
        longint t;
        t = a + b;
        if (sh > 0)
            t = floor_div(t + (longint'(1) << (sh - 1)), longint'(1) << sh);
        if (relu && t < 0)
            t = 0;
        return t > 127 ? 127 : t < -128 ? -128 : int'(t);
    endfunction

    function automatic int pool_ref(input int lane, input int i, input int mode, input int sh, input bit relu, input int bl);
        int r, c, v, m, s;
        r = i / W - 1;
        c = i % W - 1;
        m = -1000;
        s = 0;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = rq(acc_d[lane][(r + dr) * W + c + dc], bl, sh, relu);
                m = v > m ? v : m;
                s += v;
            end
        return mode == 1 ? m : int'(floor_div(s, 4));
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done && !valid_out)
                chk("done_without_valid", frame_done, 0);
            if (valid_out) begin
                if (exp_q.size() == 0)
                    chk("unexpected_out", valid_out, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_lane0", $signed(pixel_out[7:0]), mon_e.p0);
                    chk("pix_lane1", $signed(pixel_out[15:8]), mon_e.p1);
                    chk("out_cycle", cyc, mon_e.t);
                    chk("frame_done", frame_done, mon_e.last);
                end
            end
        end
    end

    task automatic run_frame(input int mode, input int sh, input bit relu, input int b0, input int b1,
                             input int gap, input bit start_beat, input int abort_at);
        exp_t e;
        bit pm;
        pm = mode == 1 || mode == 2;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_pool_mode = 2'(mode);
        cfg_shift = SW'(sh);
        cfg_relu = relu;
        cfg_bias = {b1, b0};
        valid_in = start_beat;
        acc_in = {$urandom, $urandom};
        @(posedge clk);
        #1;
        start = 1'b0;
        valid_in = 1'b0;
        cfg_shift = SW'($urandom);
        cfg_relu = 1'($urandom);
        cfg_pool_mode = 2'($urandom);
        cfg_bias = {$urandom, $urandom};
        chk("busy_run", busy, 1);
        chk("err_cleared", err_overrun, 0);
        for (int i = 0; i < N; i++) begin
            while ($urandom_range(99) < gap) begin
                @(posedge clk);
                #1;
            end
            valid_in = 1'b1;
            acc_in = {acc_d[1][i], acc_d[0][i]};
            if (!pm) begin
                e = '{cyc + 2, rq(acc_d[0][i], b0, sh, relu), rq(acc_d[1][i], b1, sh, relu), i == N - 1};
                exp_q.push_back(e);
            end else if ((i / W) % 2 == 1 && (i % W) % 2 == 1) begin
                e = '{cyc + 3, pool_ref(0, i, mode, sh, relu, b0), pool_ref(1, i, mode, sh, relu, b1), i == N - 1};
                exp_q.push_back(e);
            end
            if (i == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst_valid_out", valid_out, 0);
                chk("rst_pixel_out", pixel_out, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_done", frame_done, 0);
                exp_q.delete();
                valid_in = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            @(posedge clk);
        chk("drain_outputs", exp_q.size(), 0);
        @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    function automatic int rnd_val();
        return $urandom_range(2) == 0 ? int'($urandom) : int'($urandom_range(600)) - 300;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid_out", valid_out, 0);
        chk("reset_pixel_out", pixel_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_err", err_overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) begin
            acc_d[0][i] = i - 8;
            acc_d[1][i] = i - 8;
        end
        run_frame(0, 0, 1'b1, 0, 0, 0, 1'b0, -1);

        acc_d[0][0] = 6; acc_d[0][1] = -6; acc_d[0][2] = 5; acc_d[0][3] = 1000; acc_d[0][4] = -1000;
        for (int i = 0; i < N; i++) begin
            if (i > 4)
                acc_d[0][i] = rnd_val();
            acc_d[1][i] = acc_d[0][i];
        end
        run_frame(0, 2, 1'b0, 0, 4, 0, 1'b0, -1);

        for (int i = 0; i < N; i++) begin
            acc_d[0][i] = i;
            acc_d[1][i] = i;
        end
        run_frame(1, 0, 1'b1, 0, -100, 0, 1'b0, -1);
        run_frame(2, 0, 1'b0, 0, 0, 0, 1'b0, -1);
        run_frame(2, 0, 1'b0, 0, 0, 50, 1'b0, -1);
        run_frame(3, 1, 1'b0, 3, -3, 20, 1'b0, -1);

        @(posedge clk);
        #1;
        valid_in = 1'b1;
        acc_in = {$urandom, $urandom};
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("err_set", err_overrun, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", err_overrun, 1);

        for (int i = 0; i < N; i++) begin
            acc_d[0][i] = rnd_val();
            acc_d[1][i] = rnd_val();
        end
        run_frame(1, 3, 1'b0, rnd_val(), rnd_val(), 10, 1'b1, -1);
        run_frame(2, 1, 1'b0, 0, 0, 10, 1'b0, 6);
        run_frame(2, 1, 1'b0, 7, -7, 10, 1'b0, -1);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                acc_d[0][i] = rnd_val();
                acc_d[1][i] = rnd_val();
            end
            run_frame(int'($urandom_range(3)), $urandom_range(2) == 0 ? int'($urandom_range(31)) : int'($urandom_range(4)),
                      1'($urandom), rnd_val(), rnd_val(), int'($urandom_range(40)), 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
